// File: rtl/blood_pkg.sv
// Shared blood-bar constants and state encoding for the player health controller
// and the HUD renderer.
package blood_pkg;
  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } blood_state_e;

  localparam int FULL_NORMAL = 50;
  localparam int FULL_GOD    = 300;
  localparam int BLOOD_W     = 10;
  // one bit of headroom so blood + heal cannot wrap before clamping
  localparam int ARITH_W     = 11;

  function automatic logic [ARITH_W-1:0] clamp_max(input logic [ARITH_W-1:0] v,
                                                   input logic [ARITH_W-1:0] m);
    return (v > m) ? m : v;
  endfunction
endpackage

// File: rtl/blood_controller_if.sv
// Game-side bundle for blood_controller: damage/heal handshakes, mode inputs and
// the health outputs. The game drives through master; the controller is the slave.
interface blood_controller_if #(
  parameter int NUM_REQ = 4,
  parameter int AMT_W   = 8
);
  logic                          Frame_Tick;
  logic [NUM_REQ-1:0]            Dmg_Req;
  logic [NUM_REQ*AMT_W-1:0]      Dmg_Amount;
  logic [NUM_REQ-1:0]            Dmg_Ack;
  logic                          Heal_Req;
  logic [AMT_W-1:0]              Heal_Amount;
  logic                          Heal_Ack;
  logic                          Godmode_On;
  logic                          Restart;
  logic [blood_pkg::BLOOD_W-1:0] Player_Blood;
  logic                          Player_Dead;
  logic                          Hit_Flash;

  modport master (
    output Frame_Tick, Dmg_Req, Dmg_Amount, Heal_Req, Heal_Amount, Godmode_On, Restart,
    input  Dmg_Ack, Heal_Ack, Player_Blood, Player_Dead, Hit_Flash
  );
  modport slave (
    input  Frame_Tick, Dmg_Req, Dmg_Amount, Heal_Req, Heal_Amount, Godmode_On, Restart,
    output Dmg_Ack, Heal_Ack, Player_Blood, Player_Dead, Hit_Flash
  );
endinterface

// File: rtl/blood_controller_rr_arbiter.sv
// Round-robin arbiter: grants the first eligible requester at or after ptr.
// Returns the one-hot grant plus its index for amount selection.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic [NUM_REQ-1:0]         elig,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       gnt_vld,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);
  localparam int PTR_W = $clog2(NUM_REQ);
  int idx;

  // walk offsets from farthest to nearest so the nearest eligible wins
  always_comb begin
    grant   = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
    if (gnt_vld) grant[gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/blood_controller.sv
// Player health register and event sequencer (damage, heal, god mode, invuln, death).
// Define BLOOD_REGEN_EN to build the frame-driven +1 regeneration path.
module blood_controller #(
  parameter int NUM_REQ       = 4,
  parameter int AMT_W         = 8,
  parameter int FULL_NORMAL   = blood_pkg::FULL_NORMAL,
  parameter int FULL_GOD      = blood_pkg::FULL_GOD,
  parameter int INVULN_FRAMES = 30,
  parameter int REGEN_FRAMES  = 60
) (
  input logic               Clk,
  input logic               Reset,
  blood_controller_if.slave bus
);
  import blood_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int FW    = $clog2(INVULN_FRAMES + 1);

  blood_state_e               state, state_nx;
  logic [BLOOD_W-1:0]         blood, blood_nx;
  logic [PTR_W-1:0]           ptr, ptr_nx;
  logic [NUM_REQ-1:0]         dmg_ack, dmg_ack_nx;
  logic                       heal_ack, heal_ack_nx;
  logic [FW-1:0]              frame_cnt, frame_nx;
  logic                       god_q;
`ifdef BLOOD_REGEN_EN
  localparam int RW = $clog2(REGEN_FRAMES + 1);
  logic [RW-1:0]              regen_cnt, regen_nx;
`endif

  logic [NUM_REQ-1:0]         grant;
  logic                       gnt_vld;
  logic [PTR_W-1:0]           gnt_idx;
  logic [ARITH_W-1:0]         max_b, cur, amt, hamt;

  // a requester already holding its ack is masked so its held Req is not re-served
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .ptr     (ptr),
    .elig    (bus.Dmg_Req & ~dmg_ack),
    .grant   (grant),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign max_b = bus.Godmode_On ? ARITH_W'(FULL_GOD) : ARITH_W'(FULL_NORMAL);
  assign cur   = ARITH_W'(blood);
  assign amt   = ARITH_W'(bus.Dmg_Amount[gnt_idx*AMT_W +: AMT_W]);
  assign hamt  = ARITH_W'(bus.Heal_Amount);

  always_comb begin
    state_nx    = state;
    blood_nx    = blood;
    ptr_nx      = ptr;
    dmg_ack_nx  = '0;
    heal_ack_nx = 1'b0;
    frame_nx    = frame_cnt;
`ifdef BLOOD_REGEN_EN
    regen_nx    = regen_cnt;
`endif
    // invuln timer runs underneath every event except restart and applied hits
    if (state == INVULN && bus.Frame_Tick) begin
      if (frame_cnt == FW'(INVULN_FRAMES - 1)) begin
        state_nx = ALIVE;
        frame_nx = '0;
      end else begin
        frame_nx = frame_cnt + 1'b1;
      end
    end

    if (bus.Restart) begin
      blood_nx = BLOOD_W'(max_b);
      state_nx = ALIVE;
      frame_nx = '0;
`ifdef BLOOD_REGEN_EN
      regen_nx = '0;
`endif
    end else if (bus.Godmode_On != god_q) begin
      blood_nx = bus.Godmode_On ? BLOOD_W'(FULL_GOD)
                                : BLOOD_W'(clamp_max(cur, ARITH_W'(FULL_NORMAL)));
`ifdef BLOOD_REGEN_EN
      regen_nx = '0;
`endif
    end else if (gnt_vld) begin
      dmg_ack_nx = grant;
      ptr_nx     = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef BLOOD_REGEN_EN
      regen_nx   = '0;
`endif
      if (state == ALIVE) begin
        if (amt >= cur) begin
          blood_nx = '0;
          state_nx = DEAD;
        end else begin
          blood_nx = BLOOD_W'(cur - amt);
          state_nx = INVULN;
          frame_nx = '0;
        end
      end
    end else if (bus.Heal_Req && !heal_ack) begin
      heal_ack_nx = 1'b1;
`ifdef BLOOD_REGEN_EN
      regen_nx    = '0;
`endif
      if (state != DEAD) blood_nx = BLOOD_W'(clamp_max(cur + hamt, max_b));
    end else begin
`ifdef BLOOD_REGEN_EN
      if (state == ALIVE && bus.Frame_Tick) begin
        if (regen_cnt == RW'(REGEN_FRAMES - 1)) begin
          regen_nx = '0;
          blood_nx = BLOOD_W'(clamp_max(cur + 1'b1, max_b));
        end else begin
          regen_nx = regen_cnt + 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ALIVE;
      blood     <= BLOOD_W'(FULL_NORMAL);
      ptr       <= '0;
      dmg_ack   <= '0;
      heal_ack  <= 1'b0;
      frame_cnt <= '0;
      god_q     <= 1'b0;
`ifdef BLOOD_REGEN_EN
      regen_cnt <= '0;
`endif
    end else begin
      state     <= state_nx;
      blood     <= blood_nx;
      ptr       <= ptr_nx;
      dmg_ack   <= dmg_ack_nx;
      heal_ack  <= heal_ack_nx;
      frame_cnt <= frame_nx;
      god_q     <= bus.Godmode_On;
`ifdef BLOOD_REGEN_EN
      regen_cnt <= regen_nx;
`endif
    end
  end

  assign bus.Dmg_Ack      = dmg_ack;
  assign bus.Heal_Ack     = heal_ack;
  assign bus.Player_Blood = blood;
  assign bus.Player_Dead  = (state == DEAD);
  assign bus.Hit_Flash    = (state == INVULN);
endmodule

// File: tb/tb_blood_controller.sv
// Bench for blood_controller: directed scenarios plus random traffic, all checked
// every cycle against an event-level health model.
module tb_blood_controller;
  localparam int NR = 4, AW = 8, FN = 50, FG = 300, INV_F = 30, REG_F = 60;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  blood_controller_if #(.NUM_REQ(NR), .AMT_W(AW)) bus();
  blood_controller #(.NUM_REQ(NR), .AMT_W(AW), .FULL_NORMAL(FN), .FULL_GOD(FG),
                     .INVULN_FRAMES(INV_F), .REGEN_FRAMES(REG_F))
    dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int total = 0, bad = 0;

  // model: st 0=alive 1=invuln 2=dead; hits counts ticks seen while invulnerable
  int m_blood, m_st, m_hits, m_regen, m_ptr;
  bit m_god, m_hack;
  bit [NR-1:0] m_dack;
  int order[$];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step();
    int mx, g, a, st0, r;
    bit [NR-1:0] nd;
    bit nh;
    mx = bus.Godmode_On ? FG : FN;
    st0 = m_st; nd = '0; nh = 0; g = -1;
    if (st0 == 1 && bus.Frame_Tick) begin
      m_hits++;
      if (m_hits == INV_F) begin m_st = 0; m_hits = 0; end
    end
    for (int k = 0; k < NR; k++) begin
      r = (m_ptr + k) % NR;
      if (g < 0 && bus.Dmg_Req[r] && !m_dack[r]) g = r;
    end
    if (bus.Restart) begin
      m_blood = mx; m_st = 0; m_hits = 0; m_regen = 0;
    end else if (bus.Godmode_On != m_god) begin
      m_blood = bus.Godmode_On ? FG : imin(m_blood, FN);
      m_regen = 0;
    end else if (g >= 0) begin
      nd[g] = 1; m_ptr = (g + 1) % NR; m_regen = 0;
      a = int'(bus.Dmg_Amount[g*AW +: AW]);
      if (st0 == 0) begin
        m_blood = (m_blood > a) ? m_blood - a : 0;
        if (m_blood == 0) m_st = 2;
        else begin m_st = 1; m_hits = 0; end
      end
    end else if (bus.Heal_Req && !m_hack) begin
      nh = 1; m_regen = 0;
      if (st0 != 2) m_blood = imin(m_blood + int'(bus.Heal_Amount), mx);
    end else begin
`ifdef BLOOD_REGEN_EN
      if (st0 == 0 && bus.Frame_Tick) begin
        m_regen++;
        if (m_regen == REG_F) begin m_regen = 0; m_blood = imin(m_blood + 1, mx); end
      end
`endif
    end
    m_god = bus.Godmode_On; m_dack = nd; m_hack = nh;
  endtask

  task automatic cyc();
    bit [NR-1:0] old_d;
    bit old_h;
    old_d = m_dack; old_h = m_hack;
    model_step();
    @(posedge Clk); #1;
    chk("blood", int'(bus.Player_Blood), m_blood);
    chk("dead", int'(bus.Player_Dead), int'(m_st == 2));
    chk("flash", int'(bus.Hit_Flash), int'(m_st == 1));
    chk("dmg_ack", int'(bus.Dmg_Ack), int'(m_dack));
    chk("heal_ack", int'(bus.Heal_Ack), int'(m_hack));
    for (int i = 0; i < NR; i++) if (bus.Dmg_Ack[i]) order.push_back(i);
    bus.Frame_Tick = 1'b0; bus.Restart = 1'b0;
    // requesters release the cycle after they saw their ack
    bus.Dmg_Req = bus.Dmg_Req & ~old_d;
    if (old_h) bus.Heal_Req = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.Dmg_Req = '0; bus.Dmg_Amount = '0; bus.Heal_Req = 1'b0; bus.Heal_Amount = '0;
    bus.Frame_Tick = 1'b0; bus.Restart = 1'b0; bus.Godmode_On = 1'b0;
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
    m_blood = FN; m_st = 0; m_hits = 0; m_regen = 0; m_ptr = 0;
    m_god = 0; m_hack = 0; m_dack = '0;
  endtask

  task automatic dmg(input int i, input int a);
    bus.Dmg_Amount[i*AW +: AW] = AW'(a);
    bus.Dmg_Req[i] = 1'b1;
  endtask

  task automatic heal(input int a);
    bus.Heal_Amount = AW'(a);
    bus.Heal_Req = 1'b1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin bus.Frame_Tick = 1'b1; cyc(); cyc(); end
  endtask

  initial begin
    do_reset();
    chk("rst_blood", int'(bus.Player_Blood), 50);
    chk("rst_dead", int'(bus.Player_Dead), 0);
    chk("rst_flash", int'(bus.Hit_Flash), 0);
    chk("rst_acks", int'({bus.Dmg_Ack, bus.Heal_Ack}), 0);

    // single hit, then flash held for exactly INV_F ticks
    dmg(2, 7); cyc();
    chk("s1_ack2", int'(bus.Dmg_Ack), 4);
    chk("s1_blood", int'(bus.Player_Blood), 43);
    cyc();
    for (int t = 1; t <= INV_F; t++) begin
      bus.Frame_Tick = 1'b1; cyc();
      if (t == INV_F - 1) chk("s1_flash_29", int'(bus.Hit_Flash), 1);
      if (t == INV_F) chk("s1_flash_30", int'(bus.Hit_Flash), 0);
      cyc();
    end

    // four simultaneous requesters served in rotation
    do_reset();
    order.delete();
    for (int i = 0; i < NR; i++) dmg(i, 1);
    repeat (6) cyc();
    chk("s2_nacks", order.size(), 4);
    for (int i = 0; i < order.size(); i++) chk("s2_order", order[i], i);
    chk("s2_blood", int'(bus.Player_Blood), 49);

    // death, discarded heal, restart
    do_reset();
    dmg(0, 45); cyc(); cyc();
    chk("s3_blood5", int'(bus.Player_Blood), 5);
    ticks(INV_F);
    dmg(1, 20); cyc();
    chk("s3_dead", int'(bus.Player_Dead), 1);
    chk("s3_blood0", int'(bus.Player_Blood), 0);
    cyc();
    heal(10); cyc();
    chk("s3_heal_ack", int'(bus.Heal_Ack), 1);
    chk("s3_heal_blood", int'(bus.Player_Blood), 0);
    cyc();
    bus.Restart = 1'b1; cyc();
    chk("s3_restart", int'(bus.Player_Blood), 50);
    chk("s3_alive", int'(bus.Player_Dead), 0);

    // god mode transitions and heal clamp
    do_reset();
    bus.Godmode_On = 1'b1; cyc();
    chk("s4_god", int'(bus.Player_Blood), 300);
    dmg(3, 10); cyc();
    chk("s4_hit", int'(bus.Player_Blood), 290);
    cyc();
    bus.Godmode_On = 1'b0; cyc();
    chk("s4_fall", int'(bus.Player_Blood), 50);
    do_reset();
    dmg(0, 5); cyc(); cyc();
    heal(40); cyc();
    chk("s4_heal_clamp", int'(bus.Player_Blood), 50);
    cyc();

    // damage wins the cycle, heal follows
    do_reset();
    dmg(1, 3); heal(2); cyc();
    chk("s5_dack", int'(bus.Dmg_Ack), 2);
    chk("s5_hack0", int'(bus.Heal_Ack), 0);
    cyc();
    chk("s5_hack1", int'(bus.Heal_Ack), 1);
    chk("s5_blood", int'(bus.Player_Blood), 49);
    cyc();

    // regeneration over 120 idle frames
    do_reset();
    dmg(0, 10); cyc(); cyc();
    ticks(INV_F);
    ticks(120);
`ifdef BLOOD_REGEN_EN
    chk("s6_regen", int'(bus.Player_Blood), 42);
`else
    chk("s6_noregen", int'(bus.Player_Blood), 40);
`endif

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bus.Frame_Tick = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NR; i++)
        if (!bus.Dmg_Req[i] && $urandom_range(0, 5) == 0) dmg(i, $urandom_range(0, 25));
      if (!bus.Heal_Req && $urandom_range(0, 7) == 0) heal($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) bus.Godmode_On = ~bus.Godmode_On;
      if ($urandom_range(0, 119) == 0) bus.Restart = 1'b1;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
